// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: turns PC-stage fetch requests into a req/ack SRAM handshake.
// Optional IF_ADDR_CHECK_EN: misaligned PCs return a nop flagged with if_adel_o instead of fetching.
module inst_fetch_resp #(
  parameter logic [31:0] RESET_ADDR = 32'hBFC0_0000
) (
  input  logic        cpu_clk_75M,
  input  logic        cpu_rst,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        stallreq_if,
  output logic        if_adel_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      state_reg, state_next;
  logic        inst_req_next;
  logic [31:0] inst_addr_next;
  logic [31:0] pc_q_reg, pc_q_next;
  logic [31:0] inst_next;
  logic [31:0] inst_pc_next;
  logic        inst_valid_next;
  logic        consume;
  logic        issue;

  // Only stall[1] (IF/ID hold) matters here.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5:2], stall[0]};

  assign consume = inst_valid_o & ~stall[1];
  assign issue   = ce & ~flush & (~inst_valid_o | ~stall[1]);

  // Held through the ack cycle so the PC advances only at the issuing edge.
  assign stallreq_if = (state_reg == S_WAIT) | (state_reg == S_DROP) | (inst_valid_o & stall[1]);

`ifdef IF_ADDR_CHECK_EN
  logic if_adel_next;
`endif

  always_comb begin
    state_next      = state_reg;
    inst_req_next   = inst_req;
    inst_addr_next  = inst_addr;
    pc_q_next       = pc_q_reg;
    inst_next       = inst_o;
    inst_pc_next    = inst_pc_o;
    inst_valid_next = inst_valid_o & ~consume;
`ifdef IF_ADDR_CHECK_EN
    if_adel_next    = if_adel_o & ~consume;
`endif

    case (state_reg)
      S_IDLE: begin
`ifdef IF_ADDR_CHECK_EN
        if (issue && (pc[1:0] != 2'b00)) begin
          inst_next       = 32'h0000_0000;
          inst_pc_next    = pc;
          inst_valid_next = 1'b1;
          if_adel_next    = 1'b1;
        end else
`endif
        if (issue) begin
          state_next     = S_WAIT;
          inst_req_next  = 1'b1;
          inst_addr_next = {pc[31:2], 2'b00};
          pc_q_next      = pc;
        end
      end
      S_WAIT: begin
        if (inst_ack) begin
          inst_req_next = 1'b0;
          state_next    = S_IDLE;
          if (!flush) begin
            inst_next       = inst_rdata;
            inst_pc_next    = pc_q_reg;
            inst_valid_next = 1'b1;
`ifdef IF_ADDR_CHECK_EN
            if_adel_next    = 1'b0;
`endif
          end
        end else if (flush) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        // The bus cannot cancel, so wait out the orphaned response.
        if (inst_ack) begin
          inst_req_next = 1'b0;
          state_next    = S_IDLE;
        end
      end
      default: begin
        state_next    = S_IDLE;
        inst_req_next = 1'b0;
      end
    endcase

    if (flush) begin
      inst_valid_next = 1'b0;
`ifdef IF_ADDR_CHECK_EN
      if_adel_next    = 1'b0;
`endif
    end
  end

  always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_reg    <= S_IDLE;
      inst_req     <= 1'b0;
      inst_addr    <= RESET_ADDR;
      pc_q_reg     <= RESET_ADDR;
      inst_o       <= 32'h0000_0000;
      inst_pc_o    <= RESET_ADDR;
      inst_valid_o <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inst_req     <= inst_req_next;
      inst_addr    <= inst_addr_next;
      pc_q_reg     <= pc_q_next;
      inst_o       <= inst_next;
      inst_pc_o    <= inst_pc_next;
      inst_valid_o <= inst_valid_next;
    end
  end

`ifdef IF_ADDR_CHECK_EN
  always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
    if (cpu_rst) begin
      if_adel_o <= 1'b0;
    end else begin
      if_adel_o <= if_adel_next;
    end
  end
`else
  assign if_adel_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: acts as PC stage and SRAM bus, with a fetch-level reference model.
// Honours IF_ADDR_CHECK_EN the same way the design does.
module tb_inst_fetch_resp;

  localparam logic [31:0] RESET_ADDR = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stallreq_if;
  logic        if_adel_o;

  inst_fetch_resp #(.RESET_ADDR(RESET_ADDR)) dut (
    .cpu_clk_75M (clk),
    .cpu_rst     (cpu_rst),
    .pc          (pc),
    .ce          (ce),
    .stall       (stall),
    .flush       (flush),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_ack    (inst_ack),
    .inst_rdata  (inst_rdata),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o),
    .inst_valid_o(inst_valid_o),
    .stallreq_if (stallreq_if),
    .if_adel_o   (if_adel_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one outstanding fetch plus one buffered instruction.
  logic [31:0] pc_cur;       // PC-stage register
  logic [31:0] redirect_pc;  // address loaded by the PC stage on flush
  logic        m_out;        // fetch outstanding on the bus
  logic        m_cancel;     // outstanding fetch was flushed
  int          m_lat;        // cycles left until the bus acks
  logic [31:0] m_pcq;
  logic [31:0] m_addr;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;
  logic        m_valid;
  logic        m_adel;
  logic        force_bad;    // bus returns DEADBEEF on its next ack

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    pc_cur   = RESET_ADDR;
    m_out    = 1'b0;
    m_cancel = 1'b0;
    m_lat    = 0;
    m_pcq    = RESET_ADDR;
    m_addr   = RESET_ADDR;
    m_inst   = 32'h0;
    m_ipc    = RESET_ADDR;
    m_valid  = 1'b0;
    m_adel   = 1'b0;
  endtask

  // One clock cycle: entered and left at a negedge.
  task automatic step(input logic ce_i, input logic st1_i, input logic fl_i, input int lat_i);
    logic        se, consume, issue, ack, n_valid, n_adel;
    logic [31:0] rdata_v;
    check_eq("inst_req", 32'(inst_req), 32'(m_out));
    check_eq("inst_addr", inst_addr, m_addr);
    check_eq("inst_valid_o", 32'(inst_valid_o), 32'(m_valid));
    check_eq("inst_o", inst_o, m_inst);
    check_eq("inst_pc_o", inst_pc_o, m_ipc);
    check_eq("if_adel_o", 32'(if_adel_o), 32'(m_adel));

    ack     = m_out && (m_lat == 1);
    rdata_v = force_bad ? 32'hDEADBEEF : mem_word(m_addr);
    pc         = pc_cur;
    ce         = ce_i;
    stall      = {4'($urandom), st1_i, 1'($urandom)};
    flush      = fl_i;
    inst_ack   = ack;
    inst_rdata = ack ? rdata_v : $urandom;
    #1;
    se = m_out | (m_valid & st1_i);
    check_eq("stallreq_if", 32'(stallreq_if), 32'(se));

    consume = m_valid & ~st1_i;
    n_valid = m_valid & ~consume;
    n_adel  = m_adel & ~consume;
    issue   = ce_i & ~fl_i & ~se;
    if (m_out) begin
      if (ack) begin
        m_out = 1'b0;
        if (!m_cancel && !fl_i) begin
          n_valid = 1'b1;
          n_adel  = 1'b0;
          m_inst  = rdata_v;
          m_ipc   = m_pcq;
        end
      end else begin
        m_lat--;
        if (fl_i) m_cancel = 1'b1;
      end
    end else if (issue) begin
`ifdef IF_ADDR_CHECK_EN
      if (pc_cur[1:0] != 2'b00) begin
        n_valid = 1'b1;
        n_adel  = 1'b1;
        m_inst  = 32'h0;
        m_ipc   = pc_cur;
      end else
`endif
      begin
        m_out    = 1'b1;
        m_cancel = 1'b0;
        m_pcq    = pc_cur;
        m_addr   = {pc_cur[31:2], 2'b00};
        m_lat    = lat_i;
      end
    end
    if (fl_i) begin
      n_valid = 1'b0;
      n_adel  = 1'b0;
      pc_cur  = redirect_pc;
    end else if (issue) begin
      pc_cur = pc_cur + 32'd4;
    end
    m_valid = n_valid;
    m_adel  = n_adel;

    @(posedge clk);
    @(negedge clk);
    if (ack) force_bad = 1'b0;
  endtask

  initial begin
    cpu_rst     = 1'b1;
    pc          = RESET_ADDR;
    ce          = 1'b0;
    stall       = 6'b0;
    flush       = 1'b0;
    inst_ack    = 1'b0;
    inst_rdata  = 32'h0;
    force_bad   = 1'b0;
    redirect_pc = RESET_ADDR;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_inst_req", 32'(inst_req), 32'h0);
    check_eq("rst_inst_addr", inst_addr, RESET_ADDR);
    check_eq("rst_inst_pc_o", inst_pc_o, RESET_ADDR);
    check_eq("rst_inst_o", inst_o, 32'h0);
    check_eq("rst_valid", 32'(inst_valid_o), 32'h0);
    check_eq("rst_adel", 32'(if_adel_o), 32'h0);
    cpu_rst = 1'b0;

    // First fetch, 1-cycle ack
    step(1'b1, 1'b0, 1'b0, 1);
    check_eq("first_req", 32'(inst_req), 32'h1);
    check_eq("first_addr", inst_addr, 32'hBFC0_0000);
    step(1'b0, 1'b0, 1'b0, 1);
    check_eq("first_valid", 32'(inst_valid_o), 32'h1);
    check_eq("first_inst", inst_o, mem_word(32'hBFC0_0000));
    check_eq("first_pc", inst_pc_o, 32'hBFC0_0000);
    step(1'b0, 1'b0, 1'b0, 1);

    // Three fetches with 3-cycle ack latency, ce held high
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 3);
    check_eq("stream_pc", inst_pc_o, 32'hBFC0_000C);

    // Hold the buffered instruction for 5 cycles
    step(1'b1, 1'b0, 1'b0, 1);
    step(1'b1, 1'b1, 1'b0, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1);
    check_eq("stall_inst_hold", inst_o, mem_word(32'hBFC0_0010));
    step(1'b1, 1'b0, 1'b0, 2);
    check_eq("reissue_req", 32'(inst_req), 32'h1);
    check_eq("reissue_addr", inst_addr, 32'hBFC0_0014);
    step(1'b1, 1'b0, 1'b0, 2);
    step(1'b1, 1'b0, 1'b0, 2);

    // Flush in the 2nd WAIT cycle; orphaned ack carries DEADBEEF
    step(1'b1, 1'b0, 1'b0, 4);
    step(1'b1, 1'b0, 1'b0, 4);
    redirect_pc = 32'hBFC0_0380;
    step(1'b1, 1'b0, 1'b1, 4);
    force_bad = 1'b1;
    step(1'b1, 1'b0, 1'b0, 4);
    step(1'b1, 1'b0, 1'b0, 4);
    check_eq("drop_valid", 32'(inst_valid_o), 32'h0);
    check_eq("no_deadbeef", 32'(inst_o == 32'hDEADBEEF), 32'h0);
    step(1'b1, 1'b0, 1'b0, 2);
    check_eq("redirect_addr", inst_addr, 32'hBFC0_0380);

    // Flush coincident with ack
    step(1'b1, 1'b0, 1'b0, 2);
    redirect_pc = 32'hBFC0_0400;
    step(1'b1, 1'b0, 1'b1, 2);
    check_eq("flush_ack_valid", 32'(inst_valid_o), 32'h0);
    check_eq("flush_ack_req", 32'(inst_req), 32'h0);

    // Misaligned pc
    redirect_pc = 32'hBFC0_0002;
    step(1'b0, 1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 1'b0, 1);
`ifdef IF_ADDR_CHECK_EN
    check_eq("misalign_noreq", 32'(inst_req), 32'h0);
    check_eq("misalign_adel", 32'(if_adel_o), 32'h1);
    check_eq("misalign_pc", inst_pc_o, 32'hBFC0_0002);
`else
    check_eq("misalign_addr", inst_addr, 32'hBFC0_0000);
    check_eq("misalign_adel", 32'(if_adel_o), 32'h0);
`endif
    step(1'b0, 1'b1, 1'b0, 1);
    redirect_pc = 32'hBFC0_1000;
    step(1'b0, 1'b0, 1'b1, 1);

    // Async reset mid-WAIT
    step(1'b1, 1'b0, 1'b0, 5);
    step(1'b1, 1'b0, 1'b0, 5);
    #2 cpu_rst = 1'b1;
    #1;
    check_eq("async_rst_req", 32'(inst_req), 32'h0);
    check_eq("async_rst_addr", inst_addr, RESET_ADDR);
    check_eq("async_rst_pc", inst_pc_o, RESET_ADDR);
    model_reset();
    inst_ack = 1'b0;
    @(negedge clk);
    cpu_rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0)
        redirect_pc = {4'hB, 12'($urandom), 14'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00};
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 24) == 0), int'($urandom_range(1, 4)));
    end
    step(1'b0, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
